leb128_i32_stream_decoder: RTL and testbench

//  Byte-serial controller that sequences the combinational LEB128 unpack datapath (unpack_i32 / unpack_u32).

---
 rtl/leb128_i32_stream_decoder_pkg.sv | 45 ++++
 rtl/leb128_i32_stream_decoder_if.sv | 30 +++
 rtl/leb128_i32_stream_decoder_unpack.sv | 50 +++++
 rtl/leb128_i32_stream_decoder.sv | 160 ++++++++++++++++
 tb/tb_leb128_i32_stream_decoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/leb128_i32_stream_decoder_pkg.sv
// leb128_pkg: shared constants, FSM state type and the byte-window gather
// helper used by the LEB128 stream decoder and its unpack datapaths.
//   MAX_BYTES : longest LEB128 encoding of a 32-bit value (5 bytes)
//   LEN_W     : width of a byte-length / window index
//   state_t   : controller states COLLECT, EMIT, DRAIN
//   unpack_t  : gathered 7-bit groups plus encoding length
package leb128_pkg;

   localparam int MAX_BYTES = 5;
   localparam int LEN_W     = 3;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      EMIT    = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0]      raw;
      logic [LEN_W-1:0] len;
   } unpack_t;

   // Concatenate 7-bit payload groups, LSB group first, up to and including
   // the first byte whose continuation bit is clear. A window with no
   // terminator is taken as a full 5-byte encoding. Groups past bit 31 are
   // shifted out of the 32-bit result.
   function automatic unpack_t unpack_raw(input logic [8*MAX_BYTES-1:0] w);
      unpack_t r;
      logic    done;
      r      = '0;
      r.len  = LEN_W'(MAX_BYTES);
      done   = 1'b0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (!done) begin
            r.raw = r.raw | (32'(w[8*i +: 7]) << (7*i));
            if (!w[8*i+7]) begin
               done  = 1'b1;
               r.len = LEN_W'(i + 1);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/leb128_i32_stream_decoder_if.sv
// Byte-in / word-out bus of the LEB128 stream decoder.
// Both directions use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; the source holds its data stable and
// keeps valid high until that edge, and ready never waits on a later valid.
//   in_data/in_valid/in_ready         : LEB128 bytes into the decoder
//   out_data/out_len/out_err/out_valid/out_ready : decoded values out
// Modports: slave = decoder side, master = environment side.
interface leb128_i32_stream_decoder_if;
   import leb128_pkg::*;

   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      out_data;
   logic [LEN_W-1:0] out_len;
   logic             out_err;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_len, out_err, out_valid
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_len, out_err, out_valid
   );

endinterface

// File: rtl/leb128_i32_stream_decoder_unpack.sv
// Combinational LEB128 unpack datapaths for a 5-byte window.
//   unpack_i32 : value sign-extended from bit 6 of the terminating byte
//   unpack_u32 : value zero-extended
// Ports (both): win   in  40  bytes b0 (bits 7:0) .. b4 (bits 39:32)
//               value out 32  decoded value
//               len   out 3   encoding length 1..5
module unpack_i32
   import leb128_pkg::*;
(
   input  logic [8*MAX_BYTES-1:0] win,
   output logic [31:0]            value,
   output logic [LEN_W-1:0]       len
);

   unpack_t u;
   logic    sign;

   always_comb begin
      u    = unpack_raw(win);
      sign = 1'b0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (LEN_W'(i + 1) == u.len) sign = win[8*i+6];
      end
      value = u.raw;
      // Bits above the last payload group copy its top bit.
      for (int j = 0; j < 32; j++) begin
         if (j >= 7*int'(u.len)) value[j] = sign;
      end
      len = u.len;
   end

endmodule

module unpack_u32
   import leb128_pkg::*;
(
   input  logic [8*MAX_BYTES-1:0] win,
   output logic [31:0]            value,
   output logic [LEN_W-1:0]       len
);

   unpack_t u;

   always_comb begin
      u     = unpack_raw(win);
      value = u.raw;
      len   = u.len;
   end

endmodule

// File: rtl/leb128_i32_stream_decoder.sv
// LEB128 byte-stream to 32-bit value decoder.
// Gathers bytes into a 5-byte window and, on the terminating byte, registers
// the value from the unpack datapath together with the encoding length.
// Optional feature macro: LEB128_OVERLONG_CHECK_EN -- a 5th byte with its
// continuation bit set sends the controller to DRAIN, which swallows bytes up
// to the next terminator and then reports out_err=1. Without it the 5th byte
// always terminates and out_err is constant 0.
// Ports:
//   clk      in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport: in_* byte input, out_* value output
//   val_cnt  out  values emitted (errors included), wraps
//   state    out  current controller state, for observation
// Parameters: SIGNED (1: sign-extended, 0: zero-extended), CNT_W.
module leb128_i32_stream_decoder
   import leb128_pkg::*;
#(
   parameter bit SIGNED = 1'b1,
   parameter int CNT_W  = 16
)
(
   input  logic                         clk,
   input  logic                         reset_n,
   leb128_i32_stream_decoder_if.slave   bus,
   output logic [CNT_W-1:0]             val_cnt,
   output state_t                       state
);

   state_t                 state_nxt;
   logic [8*MAX_BYTES-1:0] win;
   logic [8*MAX_BYTES-1:0] win_nxt;
   logic [LEN_W-1:0]       idx;
   logic [31:0]            dp_value;
   logic [LEN_W-1:0]       unused_len;
   logic [31:0]            out_data_r;
   logic [LEN_W-1:0]       out_len_r;
   logic                   out_valid_r;
   logic                   in_fire;
   logic                   out_fire;
   logic                   last_slot;
   logic                   is_term;
   logic                   to_drain;

   assign in_fire   = bus.in_valid & bus.in_ready;
   assign out_fire  = bus.out_valid & bus.out_ready;
   assign last_slot = (idx == LEN_W'(MAX_BYTES - 1));

`ifdef LEB128_OVERLONG_CHECK_EN
   assign is_term  = ~bus.in_data[7];
   assign to_drain = last_slot & bus.in_data[7];
`else
   assign is_term  = ~bus.in_data[7] | last_slot;
   assign to_drain = 1'b0;
`endif

   // Window as it will be after this byte: new byte at idx, older bytes kept,
   // everything above idx forced to zero so stale bytes never reach the unpacker.
   always_comb begin
      win_nxt = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (LEN_W'(i) < idx)       win_nxt[8*i +: 8] = win[8*i +: 8];
         else if (LEN_W'(i) == idx) win_nxt[8*i +: 8] = bus.in_data;
      end
   end

   generate
      if (SIGNED) begin : g_signed
         unpack_i32 u_unpack (.win(win_nxt), .value(dp_value), .len(unused_len));
      end else begin : g_unsigned
         unpack_u32 u_unpack (.win(win_nxt), .value(dp_value), .len(unused_len));
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= COLLECT;
      else          state <= state_nxt;
   end

   // in_valid is used directly: in_ready is already 1 in the accepting states.
   always_comb begin
      state_nxt    = state;
      bus.in_ready = 1'b0;
      case (state)
         COLLECT: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               if (is_term)       state_nxt = EMIT;
               else if (to_drain) state_nxt = DRAIN;
            end
         end
         EMIT: begin
            if (bus.out_ready) state_nxt = COLLECT;
         end
         DRAIN: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid && !bus.in_data[7]) state_nxt = EMIT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win         <= '0;
         idx         <= '0;
         out_data_r  <= '0;
         out_len_r   <= '0;
         out_valid_r <= 1'b0;
         val_cnt     <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (in_fire) begin
                  win <= win_nxt;
                  if (is_term) begin
                     out_data_r  <= dp_value;
                     out_len_r   <= idx + LEN_W'(1);
                     out_valid_r <= 1'b1;
                  end else if (!to_drain) begin
                     idx <= idx + LEN_W'(1);
                  end
               end
            end
            EMIT: begin
               if (out_fire) begin
                  out_valid_r <= 1'b0;
                  val_cnt     <= val_cnt + CNT_W'(1);
                  win         <= '0;
                  idx         <= '0;
               end
            end
            DRAIN: begin
               if (in_fire && !bus.in_data[7]) begin
                  out_data_r  <= '0;
                  out_len_r   <= LEN_W'(MAX_BYTES);
                  out_valid_r <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LEB128_OVERLONG_CHECK_EN
   logic out_err_r;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                           out_err_r <= 1'b0;
      else if (state == DRAIN && in_fire && !bus.in_data[7])  out_err_r <= 1'b1;
      else if (state == COLLECT && in_fire && is_term)        out_err_r <= 1'b0;
   end
   assign bus.out_err = out_err_r;
`else
   assign bus.out_err = 1'b0;
`endif

   assign bus.out_data  = out_data_r;
   assign bus.out_len   = out_len_r;
   assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_leb128_i32_stream_decoder.sv
// Directed bench for leb128_i32_stream_decoder. A signed and an unsigned
// instance receive the same byte stream in lockstep.
module tb_leb128_i32_stream_decoder;
   import leb128_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] cnt_s;
   logic [15:0] cnt_u;
   state_t      st_s;
   state_t      st_u;
   logic [15:0] exp_cnt;
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   leb128_i32_stream_decoder_if bus_s ();
   leb128_i32_stream_decoder_if bus_u ();

   leb128_i32_stream_decoder #(.SIGNED(1'b1), .CNT_W(16)) u_dut_s (
      .clk(clk), .reset_n(reset_n), .bus(bus_s), .val_cnt(cnt_s), .state(st_s)
   );

   leb128_i32_stream_decoder #(.SIGNED(1'b0), .CNT_W(16)) u_dut_u (
      .clk(clk), .reset_n(reset_n), .bus(bus_u), .val_cnt(cnt_u), .state(st_u)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic set_in(input logic [7:0] b, input logic v);
      bus_s.in_data  = b;
      bus_u.in_data  = b;
      bus_s.in_valid = v;
      bus_u.in_valid = v;
   endtask

   task automatic set_ready(input logic r);
      bus_s.out_ready = r;
      bus_u.out_ready = r;
   endtask

   // Present one byte and hold it until both decoders take it.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      set_in(b, 1'b1);
      while (!(bus_s.in_ready && bus_u.in_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", 32'(n < 50), 32'd1);
      @(posedge clk);
      #1;
      set_in(8'h00, 1'b0);
   endtask

   // Called 1 time unit after the terminating byte handshake: output must
   // already be valid, then it is consumed and the count checked.
   task automatic expect_out(input string tag, input logic [31:0] exp_s, input logic [31:0] exp_u,
                             input logic [2:0] len, input logic err);
      check({tag, "_valid_s"}, 32'(bus_s.out_valid), 32'd1);
      check({tag, "_valid_u"}, 32'(bus_u.out_valid), 32'd1);
      check({tag, "_data_s"},  bus_s.out_data, exp_s);
      check({tag, "_data_u"},  bus_u.out_data, exp_u);
      check({tag, "_len"},     32'(bus_s.out_len), 32'(len));
      check({tag, "_err"},     32'(bus_s.out_err), 32'(err));
      @(negedge clk);
      set_ready(1'b1);
      @(posedge clk);
      #1;
      set_ready(1'b0);
      exp_cnt = exp_cnt + 16'd1;
      check({tag, "_valid_clr"}, 32'(bus_s.out_valid), 32'd0);
      check({tag, "_cnt_s"},     32'(cnt_s), 32'(exp_cnt));
      check({tag, "_cnt_u"},     32'(cnt_u), 32'(exp_cnt));
   endtask

   initial begin
      // Clock/reset.
      reset_n = 1'b0;
      exp_cnt = 16'd0;
      set_in(8'h00, 1'b0);
      set_ready(1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_state",    32'(st_s), 32'(COLLECT));
      check("rst_in_ready", 32'(bus_s.in_ready), 32'd1);
      check("rst_valid",    32'(bus_s.out_valid), 32'd0);
      check("rst_data",     bus_s.out_data, 32'd0);
      check("rst_len",      32'(bus_s.out_len), 32'd0);
      check("rst_err",      32'(bus_s.out_err), 32'd0);
      check("rst_cnt",      32'(cnt_s), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Single-byte values.
      send_byte(8'h02);
      expect_out("b02", 32'h0000_0002, 32'h0000_0002, 3'd1, 1'b0);
      send_byte(8'h7E);
      expect_out("b7e", 32'hFFFF_FFFE, 32'h0000_007E, 3'd1, 1'b0);

      // Multi-byte values.
      send_byte(8'h80);
      check("mid_valid", 32'(bus_s.out_valid), 32'd0);
      check("mid_state", 32'(st_s), 32'(COLLECT));
      send_byte(8'h7F);
      expect_out("b80_7f", 32'hFFFF_FF80, 32'h0000_3F80, 3'd2, 1'b0);
      send_byte(8'hE5);
      send_byte(8'h8E);
      send_byte(8'h26);
      expect_out("b98765", 32'h0009_8765, 32'h0009_8765, 3'd3, 1'b0);

      // Five-byte maximum.
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_byte(8'h0F);
      expect_out("bmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 1'b0);

      // Backpressure: hold out_ready low, offer the next byte meanwhile.
      send_byte(8'h05);
      check("bp_state", 32'(st_s), 32'(EMIT));
      @(negedge clk);
      set_in(8'h01, 1'b1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("bp_data",     bus_s.out_data, 32'h0000_0005);
         check("bp_len",      32'(bus_s.out_len), 32'd1);
         check("bp_valid",    32'(bus_s.out_valid), 32'd1);
         check("bp_in_ready", 32'(bus_s.in_ready), 32'd0);
      end
      set_ready(1'b1);
      @(posedge clk);
      #1;
      set_ready(1'b0);
      exp_cnt = exp_cnt + 16'd1;
      check("bp_cnt",       32'(cnt_s), 32'(exp_cnt));
      check("bp_no_bypass", 32'(bus_s.out_valid), 32'd0);
      check("bp_ready_back", 32'(bus_s.in_ready), 32'd1);
      @(posedge clk);
      #1;
      set_in(8'h00, 1'b0);
      expect_out("bp_next", 32'h0000_0001, 32'h0000_0001, 3'd1, 1'b0);

      // Overlong encoding.
      for (int k = 0; k < 5; k++) send_byte(8'h80);
`ifdef LEB128_OVERLONG_CHECK_EN
      check("ovl_drain_valid", 32'(bus_s.out_valid), 32'd0);
      check("ovl_drain_state", 32'(st_s), 32'(DRAIN));
      send_byte(8'h80);
      send_byte(8'h00);
      expect_out("ovl_err", 32'h0, 32'h0, 3'd5, 1'b1);
`else
      expect_out("ovl5", 32'h0, 32'h0, 3'd5, 1'b0);
      send_byte(8'h00);
      expect_out("ovl_next", 32'h0, 32'h0, 3'd1, 1'b0);
`endif

      // Reset in the middle of a value.
      send_byte(8'h80);
      send_byte(8'h80);
      @(negedge clk);
      reset_n = 1'b0;
      #2;
      check("mrst_state", 32'(st_s), 32'(COLLECT));
      check("mrst_valid", 32'(bus_s.out_valid), 32'd0);
      check("mrst_cnt",   32'(cnt_s), 32'd0);
      #1;
      reset_n = 1'b1;
      exp_cnt = 16'd0;
      // out_ready with nothing valid must not count.
      @(negedge clk);
      set_ready(1'b1);
      @(posedge clk);
      #1;
      set_ready(1'b0);
      check("idle_ready_cnt", 32'(cnt_s), 32'd0);
      send_byte(8'h03);
      expect_out("mrst_b03", 32'h0000_0003, 32'h0000_0003, 3'd1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
